// File: rtl/controlador_puerta_pkg.sv
// Shared elevator definitions: door state encodings and default travel/re-arm timings.
package controlador_puerta_pkg;

  typedef enum logic [2:0] {
    CERRADA  = 3'd0,
    ABRIENDO = 3'd1,
    ABIERTA  = 3'd2,
    REARME   = 3'd3,
    CERRANDO = 3'd4,
    RETENIDA = 3'd5
  } estado_t;

  localparam int TRAVEL_CYCLES_DEF  = 8;
  localparam int RESTART_CYCLES_DEF = 4;
  localparam int CNT_W              = 8;

endpackage

// File: rtl/controlador_puerta_sync_flanco.sv
// Two-flop synchronizer followed by a rising-edge detector for asynchronous level inputs.
module sync_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic flanco
);

  // sr[1:0] is the synchronizer chain, sr[2] remembers the previous synchronized level
  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], din};
  end

  assign flanco = sr[1] & ~sr[2];

endmodule

// File: rtl/controlador_puerta.sv
// Elevator door controller: open/close travel timing, inhibits, re-arm and timer handshake.
module controlador_puerta
  import controlador_puerta_pkg::*;
#(
  parameter int TRAVEL_CYCLES  = TRAVEL_CYCLES_DEF,
  parameter int RESTART_CYCLES = RESTART_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       restart_n,
  input  logic       llegada_piso,
  input  logic       btn_abrir,
  input  logic       btn_cerrar,
  input  logic       peso_excesivo,
  input  logic       bloqueo_activado,
  input  logic       t_expired,
  output logic       start_timer,
  output logic       restart,
  output logic       motor_abrir,
  output logic       motor_cerrar,
  output logic       puerta_cerrada,
  output logic [2:0] estado
);

  localparam logic [CNT_W-1:0] TRAVEL_LD  = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESTART_LD = CNT_W'(RESTART_CYCLES - 1);

  estado_t          state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             armado;
  logic             exp_evt;
  logic             inhibido;

  sync_flanco u_sync_exp (
    .clk    (clk),
    .rst_n  (restart_n),
    .din    (t_expired),
    .flanco (exp_evt)
  );

  assign inhibido = peso_excesivo | bloqueo_activado;

  // armado holds the FSM still for the first edge after reset release
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    if (armado) begin
      case (state)
        CERRADA:
          if (llegada_piso || btn_abrir) begin
            nxt     = ABRIENDO;
            cnt_nxt = TRAVEL_LD;
          end
        ABRIENDO:
          if (cnt == '0) nxt = ABIERTA;
          else           cnt_nxt = cnt - 1'b1;
        ABIERTA:
          if (inhibido) nxt = RETENIDA;
          else if (btn_abrir) begin
            nxt     = REARME;
            cnt_nxt = RESTART_LD;
          end else if (btn_cerrar || exp_evt) begin
            nxt     = CERRANDO;
            cnt_nxt = TRAVEL_LD;
          end
        REARME:
          if (inhibido)        nxt = RETENIDA;
          else if (cnt == '0)  nxt = ABIERTA;
          else                 cnt_nxt = cnt - 1'b1;
        RETENIDA:
          if (!inhibido) begin
            nxt     = REARME;
            cnt_nxt = RESTART_LD;
          end
        CERRANDO:
          if (inhibido || btn_abrir) begin
            nxt     = ABRIENDO;
            cnt_nxt = TRAVEL_LD;
          end else if (cnt == '0) nxt = CERRADA;
          else                    cnt_nxt = cnt - 1'b1;
        default: begin
          nxt     = CERRADA;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with estado
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      state          <= CERRADA;
      cnt            <= '0;
      armado         <= 1'b0;
      start_timer    <= 1'b0;
      restart        <= 1'b1;
      motor_abrir    <= 1'b0;
      motor_cerrar   <= 1'b0;
      puerta_cerrada <= 1'b1;
    end else begin
      state          <= nxt;
      cnt            <= cnt_nxt;
      armado         <= 1'b1;
      start_timer    <= (nxt == ABIERTA);
      restart        <= (nxt != ABIERTA);
      motor_abrir    <= (nxt == ABRIENDO);
      motor_cerrar   <= (nxt == CERRANDO);
      puerta_cerrada <= (nxt == CERRADA);
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_controlador_puerta.sv
// Directed bench for controlador_puerta with default timings (travel 8, re-arm 4).
module tb_controlador_puerta;

  logic       clk = 1'b0;
  logic       restart_n;
  logic       llegada_piso, btn_abrir, btn_cerrar, peso_excesivo, bloqueo_activado, t_expired;
  logic       start_timer, restart, motor_abrir, motor_cerrar, puerta_cerrada;
  logic [2:0] estado;

  int checks = 0;
  int errors = 0;

  controlador_puerta dut (
    .clk              (clk),
    .restart_n        (restart_n),
    .llegada_piso     (llegada_piso),
    .btn_abrir        (btn_abrir),
    .btn_cerrar       (btn_cerrar),
    .peso_excesivo    (peso_excesivo),
    .bloqueo_activado (bloqueo_activado),
    .t_expired        (t_expired),
    .start_timer      (start_timer),
    .restart          (restart),
    .motor_abrir      (motor_abrir),
    .motor_cerrar     (motor_cerrar),
    .puerta_cerrada   (puerta_cerrada),
    .estado           (estado)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic open_door();
    llegada_piso = 1'b1;
    step(1);
    llegada_piso = 1'b0;
    step(8);
  endtask

  task automatic test_reset();
    restart_n = 1'b0;
    llegada_piso = 1'b1; btn_abrir = 1'b0; btn_cerrar = 1'b0;
    peso_excesivo = 1'b0; bloqueo_activado = 1'b0; t_expired = 1'b0;
    step(3);
    checks++;
    if ({estado, start_timer, restart, motor_abrir, motor_cerrar, puerta_cerrada} !== {3'd0, 5'b01001}) begin
      errors++;
      $display("FAIL reset_outputs: got estado=%0d st=%b rs=%b ma=%b mc=%b pc=%b, want 0 0 1 0 0 1",
               estado, start_timer, restart, motor_abrir, motor_cerrar, puerta_cerrada);
    end
  endtask

  task automatic test_open();
    restart_n = 1'b1;
    step(1);
    checks++;
    if (estado !== 3'd0) begin
      errors++; $display("FAIL first_edge_hold: estado=%0d want 0", estado);
    end
    step(1);
    llegada_piso = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (estado !== 3'd1 || motor_abrir !== 1'b1) begin
        errors++; $display("FAIL opening_cycle%0d: estado=%0d ma=%b want 1 1", i, estado, motor_abrir);
      end
      step(1);
    end
    checks++;
    if (estado !== 3'd2 || start_timer !== 1'b1 || restart !== 1'b0 || motor_abrir !== 1'b0) begin
      errors++;
      $display("FAIL opened: estado=%0d st=%b rs=%b ma=%b want 2 1 0 0", estado, start_timer, restart, motor_abrir);
    end
  endtask

  task automatic test_close_timer();
    t_expired = 1'b1;
    step(2);
    checks++;
    if (estado !== 3'd2) begin
      errors++; $display("FAIL sync_latency_early: estado=%0d want 2", estado);
    end
    step(1);
    t_expired = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (estado !== 3'd4 || motor_cerrar !== 1'b1 || motor_abrir !== 1'b0) begin
        errors++;
        $display("FAIL closing_cycle%0d: estado=%0d mc=%b ma=%b want 4 1 0", i, estado, motor_cerrar, motor_abrir);
      end
      step(1);
    end
    checks++;
    if (estado !== 3'd0 || puerta_cerrada !== 1'b1 || motor_cerrar !== 1'b0) begin
      errors++;
      $display("FAIL closed: estado=%0d pc=%b mc=%b want 0 1 0", estado, puerta_cerrada, motor_cerrar);
    end
  endtask

  task automatic test_reversal();
    open_door();
    btn_cerrar = 1'b1;
    step(1);
    btn_cerrar = 1'b0;
    step(2);
    checks++;
    if (estado !== 3'd4) begin
      errors++; $display("FAIL closing_cycle3: estado=%0d want 4", estado);
    end
    bloqueo_activado = 1'b1;
    step(1);
    bloqueo_activado = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (estado !== 3'd1 || motor_abrir !== 1'b1 || motor_cerrar !== 1'b0) begin
        errors++;
        $display("FAIL reopen_cycle%0d: estado=%0d ma=%b mc=%b want 1 1 0", i, estado, motor_abrir, motor_cerrar);
      end
      step(1);
    end
    checks++;
    if (estado !== 3'd2) begin
      errors++; $display("FAIL reopened: estado=%0d want 2", estado);
    end
  endtask

  task automatic test_retenida();
    peso_excesivo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if (estado !== 3'd5 || restart !== 1'b1 || start_timer !== 1'b0) begin
        errors++;
        $display("FAIL held_cycle%0d: estado=%0d rs=%b st=%b want 5 1 0", i, estado, restart, start_timer);
      end
    end
    peso_excesivo = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++;
      if (estado !== 3'd3 || restart !== 1'b1) begin
        errors++; $display("FAIL rearm_cycle%0d: estado=%0d rs=%b want 3 1", i, estado, restart);
      end
    end
    step(1);
    checks++;
    if (estado !== 3'd2 || start_timer !== 1'b1) begin
      errors++; $display("FAIL rearm_done: estado=%0d st=%b want 2 1", estado, start_timer);
    end
  endtask

  task automatic test_both_buttons();
    btn_abrir = 1'b1; btn_cerrar = 1'b1;
    step(1);
    btn_abrir = 1'b0; btn_cerrar = 1'b0;
    checks++;
    if (estado !== 3'd3) begin
      errors++; $display("FAIL open_wins: estado=%0d want 3", estado);
    end
    step(4);
    checks++;
    if (estado !== 3'd2) begin
      errors++; $display("FAIL rearm_return: estado=%0d want 2", estado);
    end
    btn_cerrar = 1'b1;
    step(1);
    btn_cerrar = 1'b0;
    step(8);
    checks++;
    if (estado !== 3'd0) begin
      errors++; $display("FAIL button_close: estado=%0d want 0", estado);
    end
    t_expired = 1'b1;
    step(1);
    t_expired = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      checks++;
      if (estado !== 3'd0) begin
        errors++; $display("FAIL expired_in_closed%0d: estado=%0d want 0", i, estado);
      end
    end
  endtask

  task automatic test_expired_discarded();
    llegada_piso = 1'b1;
    step(1);
    llegada_piso = 1'b0;
    step(1);
    t_expired = 1'b1;
    step(1);
    t_expired = 1'b0;
    step(6);
    checks++;
    if (estado !== 3'd2) begin
      errors++; $display("FAIL open_after_pulse: estado=%0d want 2", estado);
    end
    step(4);
    checks++;
    if (estado !== 3'd2) begin
      errors++; $display("FAIL expired_not_queued: estado=%0d want 2", estado);
    end
    btn_cerrar = 1'b1;
    step(1);
    btn_cerrar = 1'b0;
    step(8);
  endtask

  task automatic test_reset_mid();
    llegada_piso = 1'b1;
    step(1);
    llegada_piso = 1'b0;
    step(3);
    checks++;
    if (motor_abrir !== 1'b1) begin
      errors++; $display("FAIL mid_opening: ma=%b want 1", motor_abrir);
    end
    #2 restart_n = 1'b0;
    #1;
    checks++;
    if (motor_abrir !== 1'b0 || estado !== 3'd0 || restart !== 1'b1 || puerta_cerrada !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: ma=%b estado=%0d rs=%b pc=%b want 0 0 1 1", motor_abrir, estado, restart, puerta_cerrada);
    end
    step(2);
    restart_n = 1'b1;
    step(2);
    checks++;
    if (estado !== 3'd0) begin
      errors++; $display("FAIL after_reset_idle: estado=%0d want 0", estado);
    end
  endtask

  initial begin
    test_reset();
    test_open();
    test_close_timer();
    test_reversal();
    test_retenida();
    test_both_buttons();
    test_expired_discarded();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
